// File: rtl/dac_audio_pkg.sv
// Shared types and helpers for the audio sequencer in front of the delta-sigma dac.
package dac_audio_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RAMP_UP = 2'd1,
        RUN     = 2'd2,
        RAMP_DN = 2'd3
    } state_t;

    localparam logic [7:0] MIDSCALE = 8'h80;

    function automatic logic signed [7:0] sat10to8(input logic signed [9:0] v);
        if (v > 10'sd127)
            return 8'sh7f;
        else if (v < -10'sd128)
            return 8'sh80;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// Free-running sample-rate divider; tick_o marks the last cycle of each period.
module dac_tick_gen #(
    parameter int div_g = 2048
) (
    input  logic clk_i,
    input  logic res_n_i,
    output logic tick_o
);

    localparam int CW = $clog2(div_g);

    logic [CW-1:0] cnt;

    assign tick_o = (cnt == CW'(div_g - 1));

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i)
            cnt <= '0;
        else if (tick_o)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/dac_audio_ctrl.sv
// Three-source audio mixer with pop-free ramping of the dac word between 0 and midscale.
module dac_audio_ctrl
    import dac_audio_pkg::*;
#(
    parameter int msbi_g = 7,
    parameter int div_g  = 2048
) (
    input  logic              clk_i,
    input  logic              res_n_i,
    input  logic              en_i,
    input  logic [7:0]        ch0_data_i,
    input  logic              ch0_valid_i,
    output logic              ch0_ready_o,
    input  logic [7:0]        ch1_data_i,
    input  logic              ch1_valid_i,
    output logic              ch1_ready_o,
    input  logic [7:0]        ch2_data_i,
    input  logic              ch2_valid_i,
    output logic              ch2_ready_o,
    input  logic [5:0]        att_i,
    output logic              tick_o,
    output logic              running_o,
    output logic [msbi_g:0]   dac_o
);

    state_t      state;
    logic        tick;
    logic        en_q;
    logic [2:0]  full;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [2:0]  acc;
    logic [7:0]  din    [3];
    logic [7:0]  slot   [3];
    logic [7:0]  cur    [3];
    logic [7:0]  cur_nx [3];
    logic signed [7:0] sh [3];
    logic signed [9:0] sum;
    logic [7:0]  mix;
    logic [7:0]  ramp;
    logic [7:0]  ramp_nx;

    dac_tick_gen #(
        .div_g (div_g)
    ) u_tick (
        .clk_i   (clk_i),
        .res_n_i (res_n_i),
        .tick_o  (tick)
    );

    function automatic logic [msbi_g:0] widen(input logic [7:0] v);
        logic [msbi_g:0] w;
        w = '0;
        w[msbi_g -: 8] = v;
        return w;
    endfunction

    assign tick_o    = tick;
    assign running_o = (state == RUN);

    assign din[0] = ch0_data_i;
    assign din[1] = ch1_data_i;
    assign din[2] = ch2_data_i;
    assign valid  = {ch2_valid_i, ch1_valid_i, ch0_valid_i};
    assign ready  = {3{state == RUN}} & ~full;
    assign acc    = valid & ready;

    assign ch0_ready_o = ready[0];
    assign ch1_ready_o = ready[1];
    assign ch2_ready_o = ready[2];

    // The ramp may resume from any level (a RUN word can exceed midscale).
    always_comb begin
        ramp_nx = ramp;
        if (state == RAMP_UP) begin
            if (ramp < MIDSCALE)
                ramp_nx = ramp + 8'd1;
            else if (ramp > MIDSCALE)
                ramp_nx = ramp - 8'd1;
        end else if (ramp != 8'd0) begin
            ramp_nx = ramp - 8'd1;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            cur_nx[i] = full[i] ? slot[i] : cur[i];
            sh[i]     = $signed(cur_nx[i] ^ MIDSCALE) >>> att_i[2*i +: 2];
            sum       = sum + {{2{sh[i][7]}}, sh[i]};
        end
        mix = sat10to8(sum) ^ MIDSCALE;
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            state <= OFF;
            en_q  <= 1'b0;
            full  <= '0;
            ramp  <= '0;
            dac_o <= '0;
            for (int i = 0; i < 3; i++) begin
                slot[i] <= MIDSCALE;
                cur[i]  <= MIDSCALE;
            end
        end else begin
            en_q <= en_i;
            for (int i = 0; i < 3; i++)
                if (acc[i])
                    slot[i] <= din[i];

            if (state != RUN)
                full <= '0;
            else if (tick)
                full <= en_q ? acc : 3'b000;
            else
                full <= full | acc;

            if (tick) begin
                unique case (state)
                    OFF: begin
                        dac_o <= widen(ramp);
                        if (en_q)
                            state <= RAMP_UP;
                    end
                    RAMP_UP: begin
                        if (!en_q) begin
                            state <= RAMP_DN;
                        end else begin
                            ramp  <= ramp_nx;
                            dac_o <= widen(ramp_nx);
                            if (ramp_nx == MIDSCALE) begin
                                state <= RUN;
                                for (int i = 0; i < 3; i++)
                                    cur[i] <= MIDSCALE;
                            end
                        end
                    end
                    RUN: begin
                        if (!en_q) begin
                            state <= RAMP_DN;
                            ramp  <= dac_o[msbi_g -: 8];
                        end else begin
                            for (int i = 0; i < 3; i++)
                                cur[i] <= cur_nx[i];
                            dac_o <= widen(mix);
                        end
                    end
                    RAMP_DN: begin
                        if (en_q) begin
                            state <= RAMP_UP;
                        end else begin
                            ramp  <= ramp_nx;
                            dac_o <= widen(ramp_nx);
                            if (ramp_nx == 8'd0)
                                state <= OFF;
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

endmodule
